// File: rtl/gray_fifo_read_tracker_if.sv
// Read-side FIFO link: remote Gray write pointer in, local read pointer,
// occupancy/status and the dequeue/flush handshakes out.
interface gray_fifo_read_tracker_if #(
    parameter int width = 10
);
    logic [width-1:0] wrGray;
    logic             deq__ENA;
    logic             deq__RDY;
    logic             flush__ENA;
    logic             flush__RDY;
    logic [width-2:0] rdAddr;
    logic [width-1:0] rdGray;
    logic [width-1:0] count;
    logic             empty;
    logic             full;
    logic             error;

    modport master (
        output wrGray, deq__ENA, flush__ENA,
        input  deq__RDY, flush__RDY, rdAddr, rdGray, count, empty, full, error
    );

    modport slave (
        input  wrGray, deq__ENA, flush__ENA,
        output deq__RDY, flush__RDY, rdAddr, rdGray, count, empty, full, error
    );
endinterface

// File: rtl/gray_fifo_read_tracker.sv
// Read-side end of a Gray-pointer FIFO: decodes the synchronised remote write
// pointer, owns the local read pointer and reports occupancy and protocol errors.
module gray_fifo_read_tracker #(
    parameter int width = 10
) (
    input  logic                     CLK,
    input  logic                     RST,
    gray_fifo_read_tracker_if.slave  ifc
);
    // Occupancy of a completely full FIFO; the wrap bit alone set.
    localparam logic [width-1:0] DEPTH = {1'b1, {(width-1){1'b0}}};

    function automatic logic [width-1:0] gray2bin(input logic [width-1:0] g);
        logic [width-1:0] b;
        b[width-1] = g[width-1];
        for (int i = width - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [width-1:0] bin2gray(input logic [width-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [width-1:0] wr_bin_q, wr_bin_d;
    logic [width-1:0] rd_bin_q, rd_bin_d;
    logic [width-1:0] rd_gray_q, rd_gray_d;
    logic             error_q, error_d;

    logic [width-1:0] count;
    logic [width-1:0] rd_bin_inc;
    logic             empty;
    logic             deq_fire;
    logic             underflow;
    logic             overflow;

    // Status is derived purely from registered pointers.
    always_comb begin
        count      = wr_bin_q - rd_bin_q;
        empty      = (count == '0);
        rd_bin_inc = rd_bin_q + width'(1);
        deq_fire   = ifc.deq__ENA & ~empty;
        underflow  = ifc.deq__ENA & empty;
        overflow   = (count > DEPTH);
    end

    always_comb begin
        wr_bin_d  = gray2bin(ifc.wrGray);
        rd_bin_d  = rd_bin_q;
        rd_gray_d = rd_gray_q;
        error_d   = error_q | underflow | overflow;
        // Flush jumps straight to the freshly decoded write pointer and
        // swallows any simultaneous dequeue.
        if (ifc.flush__ENA) begin
            rd_bin_d  = wr_bin_d;
            rd_gray_d = ifc.wrGray;
        end else if (deq_fire) begin
            rd_bin_d  = rd_bin_inc;
            rd_gray_d = bin2gray(rd_bin_inc);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_bin_q  <= '0;
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
            error_q   <= 1'b0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            rd_bin_q  <= rd_bin_d;
            rd_gray_q <= rd_gray_d;
            error_q   <= error_d;
        end
    end

    assign ifc.count      = count;
    assign ifc.empty      = empty;
    assign ifc.full       = (count == DEPTH);
    assign ifc.deq__RDY   = ~empty;
    assign ifc.flush__RDY = 1'b1;
    assign ifc.rdAddr     = rd_bin_q[width-2:0];
    assign ifc.rdGray     = rd_gray_q;
    assign ifc.error      = error_q;
endmodule

// File: tb/tb_gray_fifo_read_tracker.sv
// Bench for gray_fifo_read_tracker at width 4: directed vector table followed
// by model-scored sequences for streaming, flush, overflow and reset.
module tb_gray_fifo_read_tracker;
    localparam int W = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    gray_fifo_read_tracker_if #(.width(W)) ifc ();

    gray_fifo_read_tracker #(.width(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .ifc (ifc)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        bit         rst;
        logic [3:0] wr;
        bit         deq;
        bit         flush;
        logic [15:0] exp;
    } vec_t;

    vec_t        tbl[11];
    logic [15:0] exp_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;

    int m_wr, m_rd;
    bit m_err;

    function automatic logic [15:0] pk(int cnt, bit emp, bit ful, bit rdy,
                                       int rg, int ra, bit err);
        logic [3:0] c4, g4;
        logic [2:0] a3;
        c4 = cnt[3:0];
        g4 = rg[3:0];
        a3 = ra[2:0];
        return {c4, emp, ful, rdy, g4, a3, err, 1'b1};
    endfunction

    function automatic logic [3:0] b2g(int b);
        int x;
        x = (b ^ (b >> 1)) & 15;
        return x[3:0];
    endfunction

    function automatic int g2b(logic [3:0] g);
        int x, r;
        x = int'(g);
        r = 0;
        while (x != 0) begin
            r = r ^ x;
            x = x >> 1;
        end
        return r;
    endfunction

    function automatic logic [15:0] dut_out();
        return {ifc.count, ifc.empty, ifc.full, ifc.deq__RDY, ifc.rdGray,
                ifc.rdAddr, ifc.error, ifc.flush__RDY};
    endfunction

    task automatic check(string name, int got, int need);
        n_vec++;
        if (got != need) begin
            n_miss++;
            $display("FAIL %s: got %0d, need %0d", name, got, need);
        end
    endtask

    // Drive one cycle, queue its expectation, then compare after the edge.
    task automatic apply(bit rst, logic [3:0] wg, bit deq, bit flush,
                         logic [15:0] e, string name);
        logic [15:0] got, need;
        RST            = rst;
        ifc.wrGray     = wg;
        ifc.deq__ENA   = deq;
        ifc.flush__ENA = flush;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        got  = dut_out();
        need = exp_q.pop_front();
        n_vec++;
        if (got !== need) begin
            n_miss++;
            $display("FAIL %s: got {cnt,emp,ful,rdy,gray,addr,err,frdy}=%h, need %h",
                     name, got, need);
        end
    endtask

    task automatic mstep(bit rst, logic [3:0] wg, bit deq, bit flush, string name);
        int cnt;
        if (rst) begin
            m_wr  = 0;
            m_rd  = 0;
            m_err = 0;
        end else begin
            cnt = (m_wr - m_rd) & 15;
            if ((deq && cnt == 0) || cnt > 8) m_err = 1;
            if (flush) m_rd = g2b(wg);
            else if (deq && cnt != 0) m_rd = (m_rd + 1) & 15;
            m_wr = g2b(wg);
        end
        cnt = (m_wr - m_rd) & 15;
        apply(rst, wg, deq, flush,
              pk(cnt, cnt == 0, cnt == 8, cnt != 0, int'(b2g(m_rd)), m_rd & 7, m_err),
              name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_tot, rd_tot, cnt, rd_before;
        bit d, w, seen_full, seen8, seen_wrap;

        RST            = 1'b1;
        ifc.wrGray     = '0;
        ifc.deq__ENA   = 1'b0;
        ifc.flush__ENA = 1'b0;

        tbl[0]  = '{"reset",        1, 4'd0, 0, 0, pk(0, 1, 0, 0, 0, 0, 0)};
        tbl[1]  = '{"wr gray 1",    0, 4'd1, 0, 0, pk(1, 0, 0, 1, 0, 0, 0)};
        tbl[2]  = '{"wr gray 3",    0, 4'd3, 0, 0, pk(2, 0, 0, 1, 0, 0, 0)};
        tbl[3]  = '{"wr gray 2",    0, 4'd2, 0, 0, pk(3, 0, 0, 1, 0, 0, 0)};
        tbl[4]  = '{"deq 1",        0, 4'd2, 1, 0, pk(2, 0, 0, 1, 1, 1, 0)};
        tbl[5]  = '{"deq 2",        0, 4'd2, 1, 0, pk(1, 0, 0, 1, 3, 2, 0)};
        tbl[6]  = '{"deq 3",        0, 4'd2, 1, 0, pk(0, 1, 0, 0, 2, 3, 0)};
        tbl[7]  = '{"underflow",    0, 4'd2, 1, 0, pk(0, 1, 0, 0, 2, 3, 1)};
        tbl[8]  = '{"error sticky", 0, 4'd2, 0, 0, pk(0, 1, 0, 0, 2, 3, 1)};
        tbl[9]  = '{"re-reset",     1, 4'd0, 0, 0, pk(0, 1, 0, 0, 0, 0, 0)};
        tbl[10] = '{"idle",         0, 4'd0, 0, 0, pk(0, 1, 0, 0, 0, 0, 0)};

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].rst, tbl[i].wr, tbl[i].deq, tbl[i].flush, tbl[i].exp, tbl[i].name);
        end

        // Stream 20 entries, never exceeding a full FIFO.
        mstep(1, 4'd0, 0, 0, "stream reset");
        wr_tot    = 0;
        rd_tot    = 0;
        seen_full = 0;
        seen8     = 0;
        seen_wrap = 0;
        for (int i = 0; i < 200 && rd_tot < 20; i++) begin
            cnt = wr_tot - rd_tot;
            d   = (i >= 8) && (i % 3 != 2) && (cnt > 0);
            w   = (wr_tot < 20) && ((wr_tot + 1) - (rd_tot + int'(d)) <= 8);
            if (w) wr_tot++;
            if (d) rd_tot++;
            mstep(0, b2g(wr_tot & 15), d, 0, "stream");
            if (ifc.full) seen_full = 1;
            if (ifc.rdGray == 4'b1000) seen8 = 1;
            if (seen8 && ifc.rdGray == 4'b0000) seen_wrap = 1;
        end
        check("stream drained", rd_tot, 20);
        check("stream saw full", int'(seen_full), 1);
        check("stream rdGray 1000", int'(seen8), 1);
        check("stream rdGray wrap 0000", int'(seen_wrap), 1);
        check("stream error clear", int'(ifc.error), 0);

        // Flush together with deq from count=5.
        mstep(1, 4'd0, 0, 0, "flush reset");
        mstep(0, b2g(3), 0, 0, "flush fill 3");
        for (int i = 0; i < 3; i++) mstep(0, b2g(3), 1, 0, "flush pre-deq");
        mstep(0, b2g(8), 0, 0, "flush fill to 5");
        check("count before flush", int'(ifc.count), 5);
        rd_before = g2b(ifc.rdGray);
        mstep(0, b2g(8), 1, 1, "flush+deq");
        check("flush count", int'(ifc.count), 0);
        check("flush rdGray==wrGray", int'(ifc.rdGray), int'(ifc.wrGray));
        check("flush advance", (g2b(ifc.rdGray) - rd_before) & 15, 5);

        // Writer laps the reader: 9 ahead.
        mstep(0, b2g(1), 0, 0, "lap 9 ahead");
        check("lap count", int'(ifc.count), 9);
        check("lap full", int'(ifc.full), 0);
        mstep(0, b2g(1), 0, 0, "lap error");
        check("overflow error", int'(ifc.error), 1);
        mstep(0, b2g(1), 0, 1, "flush keeps error");
        check("error after flush", int'(ifc.error), 1);
        mstep(1, 4'd0, 0, 0, "reset clears error");
        check("error after reset", int'(ifc.error), 0);

        // Reset in the middle of traffic.
        mstep(0, b2g(2), 0, 0, "mid fill");
        mstep(0, b2g(4), 1, 0, "mid deq");
        check("mid rdGray nonzero", int'(ifc.rdGray != 0), 1);
        mstep(1, 4'd0, 1, 0, "mid reset");
        check("mid reset count", int'(ifc.count), 0);
        check("mid reset rdGray", int'(ifc.rdGray), 0);
        mstep(0, 4'd0, 0, 0, "post reset idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
